// File: rtl/piece_dispenser_pkg.sv
// Shared game definitions: shape encoding, dispenser FSM states and a
// helper that picks the lowest shape still missing from the current bag.
package piece_dispenser_pkg;

  localparam int SHAPE_W    = 3;
  localparam int NUM_SHAPES = 7;
  localparam logic [SHAPE_W-1:0] SHAPE_NONE = 3'd7;

  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd6;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } disp_state_t;

  function automatic logic [SHAPE_W-1:0] lowest_free(input logic [NUM_SHAPES-1:0] mask);
    lowest_free = SHAPE_NONE;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (!mask[i]) lowest_free = SHAPE_W'(i);
    end
  endfunction

endpackage

// File: rtl/piece_queue.sv
// CAP-entry shift FIFO of shape ids; slot 0 is the current piece and
// slots 1..PREVIEW_DEPTH feed the preview display. Empty slots hold SHAPE_NONE.
module piece_queue
  import piece_dispenser_pkg::*;
#(
  parameter int PREVIEW_DEPTH = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [SHAPE_W-1:0]                 push_id,
  output logic [2:0]                         count,
  output logic [SHAPE_W-1:0]                 head,
  output logic [SHAPE_W*PREVIEW_DEPTH-1:0]   preview
);

  localparam int CAP = PREVIEW_DEPTH + 1;

  logic [SHAPE_W-1:0] r_slot      [CAP];
  logic [SHAPE_W-1:0] w_slot_next [CAP];
  logic [2:0]         r_count;
  logic [2:0]         w_count_next;
  logic [2:0]         w_wr_idx;

  // On a simultaneous pop the tail has already moved down by one.
  assign w_wr_idx     = pop ? (r_count - 3'd1) : r_count;
  assign w_count_next = r_count + {2'b00, push} - {2'b00, pop};

  always_comb begin
    for (int i = 0; i < CAP; i++) begin
      w_slot_next[i] = r_slot[i];
    end
    if (pop) begin
      for (int i = 0; i < CAP - 1; i++) begin
        w_slot_next[i] = r_slot[i+1];
      end
      w_slot_next[CAP-1] = SHAPE_NONE;
    end
    for (int i = 0; i < CAP; i++) begin
      if (push && (w_wr_idx == 3'(i))) w_slot_next[i] = push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CAP; i++) begin
        r_slot[i] <= SHAPE_NONE;
      end
      r_count <= 3'd0;
    end else begin
      for (int i = 0; i < CAP; i++) begin
        r_slot[i] <= w_slot_next[i];
      end
      r_count <= w_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_preview
      assign preview[gi*SHAPE_W +: SHAPE_W] = r_slot[gi+1];
    end
  endgenerate

  assign head  = r_slot[0];
  assign count = r_count;

endmodule

// File: rtl/piece_dispenser.sv
// Seven-bag piece scheduler: filters the LFSR stream against the current bag,
// forces a draw after a run of rejects, and keeps the upcoming-piece queue filled.
module piece_dispenser
  import piece_dispenser_pkg::*;
#(
  parameter int PREVIEW_DEPTH = 3,
  parameter int STARVE_LIMIT  = 63
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     rnd_id,
  input  logic                           take,
  output logic                           piece_valid,
  output logic [2:0]                     piece_id,
  output logic [3*PREVIEW_DEPTH-1:0]     preview_ids,
  output logic [2:0]                     count,
  output logic                           take_err
);

  localparam int CAP      = PREVIEW_DEPTH + 1;
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [2:0]          CAP_CNT    = 3'(CAP);

  disp_state_t                r_state, w_state_next;
  logic [NUM_SHAPES-1:0]      r_bag, w_bag_next, w_bag_set;
  logic [STARVE_W-1:0]        r_starve, w_starve_next;
  logic                       r_take_err;
  logic                       w_push, w_pop;
  logic [SHAPE_W-1:0]         w_push_id;
  logic [2:0]                 w_count, w_count_next;
  logic [NUM_SHAPES:0]        w_taken;

  // Bit 7 is permanently "taken" so the raw value 7 is rejected by the same lookup.
  assign w_taken = {1'b1, r_bag};
  assign w_pop   = take && (w_count != 3'd0);

  always_comb begin
    w_push        = 1'b0;
    w_push_id     = SHAPE_NONE;
    w_starve_next = r_starve;
    w_bag_set     = r_bag;
    w_bag_next    = r_bag;
    if (r_state == FILL) begin
      if (r_starve == STARVE_MAX) begin
        w_push    = 1'b1;
        w_push_id = lowest_free(r_bag);
      end else if (!w_taken[rnd_id]) begin
        w_push    = 1'b1;
        w_push_id = rnd_id;
      end
      if (w_push) begin
        w_starve_next = '0;
        w_bag_set     = r_bag | (7'd1 << w_push_id);
        w_bag_next    = (&w_bag_set) ? '0 : w_bag_set;
      end else begin
        w_starve_next = r_starve + 1'b1;
      end
    end
    w_count_next = w_count + {2'b00, w_push} - {2'b00, w_pop};
    w_state_next = (w_count_next == CAP_CNT) ? FULL : FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_bag      <= '0;
      r_starve   <= '0;
      r_take_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bag      <= w_bag_next;
      r_starve   <= w_starve_next;
      r_take_err <= r_take_err | (take && (w_count == 3'd0));
    end
  end

  piece_queue #(
    .PREVIEW_DEPTH (PREVIEW_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .push_id (w_push_id),
    .count   (w_count),
    .head    (piece_id),
    .preview (preview_ids)
  );

  assign count       = w_count;
  assign piece_valid = (w_count != 3'd0);
  assign take_err    = r_take_err;

endmodule

// File: tb/tb_piece_dispenser.sv
// Bench for piece_dispenser: directed scenarios plus random stimulus, all
// checked every cycle against a queue/bag reference model.
module tb_piece_dispenser;

  localparam int PD  = 3;
  localparam int SL  = 63;
  localparam int CAP = PD + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      rnd_id = 3'd7;
  logic            take = 1'b0;
  logic            piece_valid;
  logic [2:0]      piece_id;
  logic [3*PD-1:0] preview_ids;
  logic [2:0]      count;
  logic            take_err;

  int n_vec  = 0;
  int n_miss = 0;

  int mq[$];
  bit m_bag[7];
  int m_starve;
  bit m_err;

  piece_dispenser #(
    .PREVIEW_DEPTH (PD),
    .STARVE_LIMIT  (SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rnd_id      (rnd_id),
    .take        (take),
    .piece_valid (piece_valid),
    .piece_id    (piece_id),
    .preview_ids (preview_ids),
    .count       (count),
    .take_err    (take_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 7; i++) m_bag[i] = 1'b0;
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  function automatic int model_lowest_free();
    for (int i = 0; i < 7; i++) begin
      if (!m_bag[i]) return i;
    end
    return 7;
  endfunction

  task automatic model_step(input int rnd, input bit tk);
    int n;
    int id;
    int dealt;
    bit do_push;
    n       = mq.size();
    do_push = 1'b0;
    id      = 7;
    if (n < CAP) begin
      if (m_starve == SL) begin
        id = model_lowest_free();
        do_push = 1'b1;
      end else if (rnd != 7 && !m_bag[rnd]) begin
        id = rnd;
        do_push = 1'b1;
      end else begin
        m_starve++;
      end
      if (do_push) begin
        m_starve  = 0;
        m_bag[id] = 1'b1;
        dealt = 0;
        for (int i = 0; i < 7; i++) if (m_bag[i]) dealt++;
        if (dealt == 7) for (int i = 0; i < 7; i++) m_bag[i] = 1'b0;
      end
    end
    if (tk) begin
      if (n > 0) void'(mq.pop_front());
      else m_err = 1'b1;
    end
    if (do_push) mq.push_back(id);
  endtask

  task automatic check_outputs();
    logic [3*PD-1:0] exp_prev;
    int sz;
    sz = mq.size();
    for (int k = 0; k < PD; k++) begin
      exp_prev[k*3 +: 3] = (k + 1 < sz) ? 3'(mq[k+1]) : 3'd7;
    end
    chk("valid",    32'(piece_valid), 32'(sz != 0));
    chk("head",     32'(piece_id),    (sz != 0) ? 32'(mq[0]) : 32'd7);
    chk("preview",  32'(preview_ids), 32'(exp_prev));
    chk("count",    32'(count),       32'(sz));
    chk("take_err", 32'(take_err),    32'(m_err));
  endtask

  task automatic cycle(input logic [2:0] rnd, input bit tk, input bit rst);
    rnd_id = rnd;
    take   = tk;
    reset  = rst;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(int'(rnd), tk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [2:0] r;
    bit t;
    bit rs;
    model_reset();
    cycle(3'd7, 1'b0, 1'b1);
    cycle(3'd5, 1'b1, 1'b1);

    // Duplicate and 7 rejected: queue [3,5]
    cycle(3'd3, 1'b0, 1'b0);
    cycle(3'd3, 1'b0, 1'b0);
    cycle(3'd7, 1'b0, 1'b0);
    cycle(3'd5, 1'b0, 1'b0);
    chk("seq_count", 32'(count), 32'd2);
    chk("seq_head",  32'(piece_id), 32'd3);
    chk("seq_prev1", 32'(preview_ids[2:0]), 32'd5);

    // Reset mid-fill, then take on an empty queue
    cycle(3'd6, 1'b0, 1'b1);
    cycle(3'd7, 1'b1, 1'b0);
    chk("err_set", 32'(take_err), 32'd1);
    repeat (5) cycle(3'd7, 1'b0, 1'b0);
    chk("err_sticky", 32'(take_err), 32'd1);

    // Full bag 0..6 with 7 interleaved, then 0 accepted again after refill
    cycle(3'd0, 1'b0, 1'b1);
    for (int s = 0; s < 7; s++) begin
      cycle(3'((s * 3) % 7), (s >= 3), 1'b0);
      cycle(3'd7, 1'b0, 1'b0);
    end
    cycle(3'd0, 1'b1, 1'b0);

    // Starvation: forced draws 0,1,2,3 then FULL
    cycle(3'd7, 1'b0, 1'b1);
    repeat (4 * 64 + 20) cycle(3'd7, 1'b0, 1'b0);
    chk("starve_count", 32'(count), 32'd4);
    chk("starve_head",  32'(piece_id), 32'd0);
    chk("starve_prev",  32'(preview_ids), 32'(9'b011_010_001));

    // FULL [2,4,6,1]: take pops only, push lands one cycle later
    cycle(3'd7, 1'b0, 1'b1);
    cycle(3'd2, 1'b0, 1'b0);
    cycle(3'd4, 1'b0, 1'b0);
    cycle(3'd6, 1'b0, 1'b0);
    cycle(3'd1, 1'b0, 1'b0);
    cycle(3'd0, 1'b1, 1'b0);
    chk("full_take_count", 32'(count), 32'd3);
    chk("full_take_prev3", 32'(preview_ids[8:6]), 32'd7);
    cycle(3'd0, 1'b0, 1'b0);
    chk("full_refill_prev3", 32'(preview_ids[8:6]), 32'd0);

    // Simultaneous pop and push at count 2
    cycle(3'd7, 1'b0, 1'b1);
    cycle(3'd1, 1'b0, 1'b0);
    cycle(3'd2, 1'b0, 1'b0);
    cycle(3'd5, 1'b1, 1'b0);
    chk("swap_count", 32'(count), 32'd2);
    chk("swap_head",  32'(piece_id), 32'd2);
    chk("swap_tail",  32'(preview_ids[2:0]), 32'd5);

    // Random: general mix, then heavily rejected stream to hit forced draws
    cycle(3'd7, 1'b0, 1'b1);
    repeat (3000) begin
      r  = 3'($urandom_range(0, 7));
      t  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 399) == 0);
      cycle(r, t, rs);
    end
    repeat (2000) begin
      r  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
      t  = ($urandom_range(0, 29) == 0);
      cycle(r, t, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/piece_dispenser.md
# piece_dispenser

Seven-bag piece scheduler between the free-running 3-bit LFSR shape source and the game control FSM. Samples the LFSR output every cycle, rejects value 7 and shapes already dealt in the current bag, and keeps a registered queue of upcoming pieces. The head of the queue is the current piece; the next entries drive the next-piece preview display. The game FSM consumes pieces with a one-cycle `take` strobe.

## Interface
- `PREVIEW_DEPTH`, default 3: number of preview entries, legal range 1..4. Queue capacity is `CAP = PREVIEW_DEPTH+1`.
- `STARVE_LIMIT`, default 63: number of consecutive rejected draws before a forced draw.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rnd_id` in 3: raw LFSR shape value, sampled every cycle.
- `take` in 1: one-cycle strobe; pop the current piece.
- `piece_valid` out 1: queue non-empty.
- `piece_id` out 3: queue head, shapes 0..6.
- `preview_ids` out 3*PREVIEW_DEPTH: entries 1..PREVIEW_DEPTH; entry 1 is in bits [2:0]; invalid entries read 3'd7.
- `count` out 3: number of queued pieces, 0..CAP.
- `take_err` out 1: sticky; set by `take` while `piece_valid`=0; cleared only by `reset`.

## Operation
- Reset values: queue slots = 7, `count`=0, `piece_valid`=0, `piece_id`=7, `preview_ids` all 7, bag mask=0, starve counter=0, `take_err`=0, state=FILL.
- State machine, two states:
  - FILL: `count`<CAP.
  - FULL: `count`=CAP.
  - Next state is computed from the next value of `count`.
  - No draws occur in FULL.
- Draw, FILL only, evaluated on the registered `count` at the start of the cycle:
  - A draw is accepted iff `rnd_id`!=7 and `bag[rnd_id]`=0.
  - Accept: push `rnd_id` to the tail, set its bag bit, clear the starve counter.
  - Reject: increment the starve counter.
  - Forced draw: when the starve counter equals STARVE_LIMIT, push the lowest-index shape whose bag bit is 0 (regardless of `rnd_id`), then clear the counter.
- Bag refill: if setting a bag bit would make the mask 7'b1111111, the mask becomes 0 in the same cycle. No bag ever deals a duplicate.
- Pop: `take` with `piece_valid`=1 shifts the queue toward the head and writes 7 into the vacated tail slot.
- Simultaneous pop and push (FILL, `take`, accepted draw):
  - Shift first, then write the new piece at index `count`-1.
  - `count` is unchanged.
  - If `count` was 0, the push goes to the head and the take is an error, so `take_err` is set.
- `take` in FULL pops only. The push resumes the next cycle.
- `take` with `piece_valid`=0: no queue change; set `take_err`.
- `rnd_id` is trusted to be stable at the sampling edge only. No other assumptions are made about its sequence.

## Timing
- All outputs are registered. There is no combinational path from `rnd_id` or `take` to any output.
- Accepted draw in cycle N: visible on `count`, and on `piece_id` or `preview_ids`, after edge N+1.
- First `piece_valid` is no earlier than 1 cycle after `reset` deasserts.
- Worst-case time to the next piece in FILL: STARVE_LIMIT+1 cycles.
- After `take` at edge N, `piece_id` shows the former preview entry 1 from edge N+1. The game FSM must not issue back-to-back `take` faster than 1 per cycle, and each one must check `piece_valid`.
- `reset` asserted mid-fill or mid-take overrides every other action in that cycle.

## Structure
- Shared game package holds:
  - `SHAPE_W`=3, `NUM_SHAPES`=7, `SHAPE_NONE`=3'd7.
  - Shape-id encoding constants, shared with the renderer and the collision logic.
  - The dispenser state enum {FILL, FULL}.
- One sub-module, `piece_queue`: CAP-entry shift FIFO with push, pop, `count` and the flattened preview outputs.
- Bag mask, draw filter, starve counter and FSM live in `piece_dispenser`.

## Test plan
- Reset, then drive `rnd_id` sequence 3,3,7,5 with no `take` → queue [3,5], `count`=2, two cycles rejected, bag bits 3 and 5 set.
- Drive values 0..6, each once, in any order, with 7 interleaved → 7 distinct pieces pushed; mask clears to 0 after the 7th; the next 0 is accepted.
- Hold `rnd_id`=7 constantly → exactly one forced push every 64 cycles, shapes 0,1,2,3 in order; FULL reached with `count`=4; no further pushes.
- FULL queue [2,4,6,1], `take` with `rnd_id`=0 → next cycle [4,6,1,7], `count`=3; cycle after that [4,6,1,0].
- `take` in FILL with `count`=2 and an accepted draw of 5 on the same edge → `count` stays 2, head = former entry 1, tail = 5.
- `take` right after reset with `count`=0 → `take_err`=1 and stays 1; assert `reset` mid-fill → all outputs return to reset values on the next edge.
